// File: rtl/uart_rx_buffer_pkg.sv
// uart_pkg: shared types and defaults for the UART receive buffer.
`default_nettype none

package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      IDLE     = 2'd1,
      HOLD     = 2'd2
   } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if: valid/ready byte stream from the receive buffer to its consumer.
`default_nettype none

interface uart_rx_buffer_if #(
   parameter int DATA_W = uart_pkg::UART_DATA_W
);

   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface

`default_nettype wire

// File: rtl/uart_rx_buffer_sync2.sv
// uart_sync2: generic two-flop synchronizer, async active-low reset to zero.
`default_nettype none

module uart_sync2 #(
   parameter int WIDTH = 1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [WIDTH-1:0] d,
   output logic      [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: captures one byte per rx_done pulse into a show-ahead FIFO
// and presents it as a valid/ready stream with level flags and sticky overrun.
`default_nettype none

module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DATA_W      = UART_DATA_W,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = 12
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic [DATA_W-1:0]        rx_data,
   input  wire logic                     rx_done,
   uart_rx_buffer_if.master              stream,
   output logic      [$clog2(DEPTH):0]   count,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_full,
   output logic                          overrun,
   input  wire logic                     overrun_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LEVEL);

   logic              done_s;
   cap_state_t        state;
   logic [1:0]        settle;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              push;
   logic              pop;
   logic              accept;
   logic              drop;
   logic [PW-1:0]     wr_nxt;
   logic [PW-1:0]     rd_nxt;
   logic [PW-1:0]     count_nxt;

   uart_sync2 #(.WIDTH(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_done),
      .q   (done_s)
   );

   // After reset done_s reads 0 until the synchronizer has refilled, so
   // WAIT_LOW ignores it for two cycles before trusting a low level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= WAIT_LOW;
         settle <= 2'd0;
      end else begin
         case (state)
            WAIT_LOW: begin
               if (settle != 2'd2) begin
                  settle <= settle + 2'd1;
               end else if (!done_s) begin
                  state <= IDLE;
               end
            end
            IDLE:     if (done_s)  state <= HOLD;
            HOLD:     if (!done_s) state <= IDLE;
            default:  state <= WAIT_LOW;
         endcase
      end
   end

   assign push   = (state == IDLE) && done_s;
   assign pop    = stream.out_valid && stream.out_ready;
   // A full FIFO still takes the byte when the head leaves in the same cycle.
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   assign wr_nxt    = wr_ptr + {{AW{1'b0}}, accept};
   assign rd_nxt    = rd_ptr + {{AW{1'b0}}, pop};
   assign count_nxt = wr_nxt - rd_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         wr_ptr      <= wr_nxt;
         rd_ptr      <= rd_nxt;
         count       <= count_nxt;
         empty       <= (wr_nxt == rd_nxt);
         full        <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
         almost_full <= (count_nxt >= AFULL_C);
         if (drop) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr[AW-1:0]] <= rx_data;
      end
   end

   assign stream.out_data  = mem[rd_ptr[AW-1:0]];
   assign stream.out_valid = ~empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed self-checking bench for uart_rx_buffer.
`default_nettype none

module tb_uart_rx_buffer;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       overrun_clr = 1'b0;
   logic [4:0] count;
   logic       empty, full, almost_full, overrun;

   int total = 0;
   int bad   = 0;

   uart_rx_buffer_if #(.DATA_W(8)) sif ();

   uart_rx_buffer #(.DATA_W(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .stream      (sif),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // rx_done high for 'hold' cycles, then low long enough for the FSM to return to IDLE
   task automatic send(input logic [7:0] d, input int hold);
      rx_data = d;
      rx_done = 1'b1;
      tick(hold);
      rx_done = 1'b0;
      tick(3);
   endtask

   initial begin
      sif.out_ready = 1'b0;

      // 1: reset values, then release with rx_done already high
      rx_done = 1'b1;
      tick(2);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_afull", 32'(almost_full), 32'd0);
      check("rst_valid", 32'(sif.out_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b1;
      tick(10);
      check("t1_count_high", 32'(count), 32'd0);
      rx_done = 1'b0;
      tick(4);
      check("t1_count_low", 32'(count), 32'd0);
      check("t1_state_idle", 32'(dut.state), 32'(IDLE));

      // 2: single frame, visible three edges after rx_done rises
      rx_data = 8'hA5;
      rx_done = 1'b1;
      tick(2);
      check("t2_count_early", 32'(count), 32'd0);
      tick(1);
      check("t2_count", 32'(count), 32'd1);
      check("t2_valid", 32'(sif.out_valid), 32'd1);
      check("t2_data", 32'(sif.out_data), 32'hA5);
      tick(1);
      rx_done = 1'b0;
      tick(3);
      check("t2_single_push", 32'(count), 32'd1);
      sif.out_ready = 1'b1;
      tick(1);
      sif.out_ready = 1'b0;
      check("t2_drained", 32'(empty), 32'd1);

      // 3: fill 00..0F, almost_full from the 12th byte
      for (int i = 0; i < 16; i++) begin
         send(8'(i), 2);
         check("t3_count", 32'(count), 32'(i + 1));
         check("t3_afull", 32'(almost_full), ((i + 1) >= 12) ? 32'd1 : 32'd0);
      end
      check("t3_full", 32'(full), 32'd1);
      send(8'hFF, 2);
      check("t3_drop_count", 32'(count), 32'd16);
      check("t3_overrun", 32'(overrun), 32'd1);

      // 5: clear collides with another dropped push -> set wins
      rx_data = 8'hEE;
      rx_done = 1'b1;
      tick(2);
      overrun_clr = 1'b1;
      tick(1);
      overrun_clr = 1'b0;
      check("t5_set_wins", 32'(overrun), 32'd1);
      rx_done = 1'b0;
      tick(3);
      overrun_clr = 1'b1;
      tick(1);
      overrun_clr = 1'b0;
      check("t5_cleared", 32'(overrun), 32'd0);

      // drain the 3/5 contents in order
      sif.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t3_drain", 32'(sif.out_data), 32'(i));
         tick(1);
      end
      sif.out_ready = 1'b0;
      check("t3_empty", 32'(empty), 32'd1);

      // 4: full FIFO, pop coincides with push of 3C
      for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 2);
      check("t4_full_before", 32'(full), 32'd1);
      rx_data = 8'h3C;
      rx_done = 1'b1;
      tick(2);
      sif.out_ready = 1'b1;
      tick(1);
      sif.out_ready = 1'b0;
      check("t4_count", 32'(count), 32'd16);
      check("t4_full", 32'(full), 32'd1);
      check("t4_overrun", 32'(overrun), 32'd0);
      check("t4_head", 32'(sif.out_data), 32'h11);
      rx_done = 1'b0;
      tick(3);
      sif.out_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check("t4_drain", 32'(sif.out_data), 32'(8'h10 + i));
         tick(1);
      end
      check("t4_last", 32'(sif.out_data), 32'h3C);
      tick(1);
      sif.out_ready = 1'b0;
      check("t4_empty", 32'(empty), 32'd1);

      // 6: reset mid-burst while rx_done is high
      for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 2);
      check("t6_count5", 32'(count), 32'd5);
      rx_data = 8'h55;
      rx_done = 1'b1;
      tick(1);
      rst = 1'b0;
      #1;
      check("t6_async_count", 32'(count), 32'd0);
      check("t6_async_empty", 32'(empty), 32'd1);
      tick(1);
      rst = 1'b1;
      tick(6);
      check("t6_no_push_high", 32'(count), 32'd0);
      rx_done = 1'b0;
      tick(3);
      check("t6_no_push_low", 32'(count), 32'd0);
      check("t6_state_idle", 32'(dut.state), 32'(IDLE));
      send(8'h66, 2);
      check("t6_repush_count", 32'(count), 32'd1);
      check("t6_repush_data", 32'(sif.out_data), 32'h66);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
